vga_num_field: RTL and testbench



---
 rtl/vga_num_pkg.sv | 55 +++++
 rtl/bin2bcd_seq.sv | 84 ++++++++
 rtl/vga_num_field.sv | 179 +++++++++++++++++
 tb/tb_vga_num_field.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_num_pkg.sv
// rtl/vga_num_pkg.sv - theme colours, glyph codes, segment decode and FSM states for vga_num_field
// Shared by bin2bcd_seq and vga_num_field.
package vga_num_pkg;

   localparam logic [11:0] THEME0_BG = 12'h000;
   localparam logic [11:0] THEME0_FG = 12'hFFF;
   localparam logic [11:0] THEME1_BG = 12'hFFF;
   localparam logic [11:0] THEME1_FG = 12'h000;
   localparam logic [11:0] THEME2_BG = 12'hE7D;
   localparam logic [11:0] THEME2_FG = 12'h8F0;

   localparam logic [3:0] GLYPH_DASH  = 4'd10;
   localparam logic [3:0] GLYPH_BLANK = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PEND  = 2'd2
   } b2b_state_t;

   // bit n = seg n; seg7/seg8 are the middle joints, lit wherever a stroke passes the corner
   function automatic logic [8:0] code2seg(input logic [3:0] code);
      case (code)
         4'd0:    return 9'h1BF;
         4'd1:    return 9'h086;
         4'd2:    return 9'h1DB;
         4'd3:    return 9'h0CF;
         4'd4:    return 9'h1E6;
         4'd5:    return 9'h1ED;
         4'd6:    return 9'h1FD;
         4'd7:    return 9'h087;
         4'd8:    return 9'h1FF;
         4'd9:    return 9'h1EF;
         4'd10:   return 9'h1C0;
         default: return 9'h000;
      endcase
   endfunction

   function automatic logic [11:0] theme_bg(input logic [1:0] t);
      case (t)
         2'd1:    return THEME1_BG;
         2'd2:    return THEME2_BG;
         default: return THEME0_BG;
      endcase
   endfunction

   function automatic logic [11:0] theme_fg(input logic [1:0] t);
      case (t)
         2'd1:    return THEME1_FG;
         2'd2:    return THEME2_FG;
         default: return THEME0_FG;
      endcase
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble converter with valid/ready intake and frame-gated commit
// Carry out of the top nibble is kept sticky as the overflow flag.
module bin2bcd_seq
   import vga_num_pkg::*;
#(
   parameter int VALUE_W = 14,
   parameter int DIGITS  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  value_vld,
   output logic                  value_rdy,
   input  logic                  frame_start,
   output logic [DIGITS*4-1:0]   bcd,
   output logic                  ovf,
   output logic                  commit
);

   localparam int CW = $clog2(VALUE_W + 1);

   b2b_state_t           state, state_nxt;
   logic [VALUE_W-1:0]   sr, sr_nxt;
   logic [DIGITS*4-1:0]  bcd_nxt, adj;
   logic                 ovf_nxt;
   logic [CW-1:0]        cnt, cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         sr    <= '0;
         bcd   <= '0;
         ovf   <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         bcd   <= bcd_nxt;
         ovf   <= ovf_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      bcd_nxt   = bcd;
      ovf_nxt   = ovf;
      cnt_nxt   = cnt;
      value_rdy = 1'b0;
      commit    = 1'b0;
      adj       = bcd;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcd[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
      end
      case (state)
         ST_IDLE: begin
            value_rdy = 1'b1;
            if (value_vld) begin
               sr_nxt    = value;
               bcd_nxt   = '0;
               ovf_nxt   = 1'b0;
               cnt_nxt   = '0;
               state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            bcd_nxt = {adj[DIGITS*4-2:0], sr[VALUE_W-1]};
            ovf_nxt = ovf | adj[DIGITS*4-1];
            sr_nxt  = {sr[VALUE_W-2:0], 1'b0};
            cnt_nxt = cnt + 1'b1;
            if (cnt == CW'(VALUE_W - 1)) state_nxt = ST_PEND;
         end
         ST_PEND: begin
            if (frame_start) begin
               commit    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/vga_num_field.sv
// rtl/vga_num_field.sv - right-aligned nine-segment decimal field overlaid on the VGA pixel stream
// Optional blink gating compiled in with VGA_NUM_BLINK_EN.
module vga_num_field
   import vga_num_pkg::*;
#(
   parameter int         DIGITS       = 4,
   parameter int         VALUE_W      = 14,
   parameter logic [9:0] X0           = 10'd16,
   parameter logic [9:0] Y0           = 10'd16,
   parameter int         SEG_LEN      = 16,
   parameter int         SEG_THK      = 4,
   parameter int         GAP          = 4,
   parameter int         BLINK_FRAMES = 30
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [VALUE_W-1:0] value,
   input  logic               value_vld,
   output logic               value_rdy,
   input  logic               frame_start,
   input  logic [1:0]         theme,
   input  logic [9:0]         h_cnt,
   input  logic [9:0]         v_cnt,
`ifdef VGA_NUM_BLINK_EN
   input  logic               blink,
`endif
   output logic [11:0]        pixel,
   output logic               in_field
);

   localparam int CELL_W = SEG_LEN + 2*SEG_THK;
   localparam int CELL_H = 2*SEG_LEN + 3*SEG_THK;
   localparam int PITCH  = CELL_W + GAP;

   if (DIGITS < 1 || DIGITS > 8 || BLINK_FRAMES < 1) begin : g_param_chk
      $error("vga_num_field: parameter out of range");
   end

   logic [DIGITS*4-1:0] bcd, codes_nxt, disp;
   logic                ovf, commit, seen;

   bin2bcd_seq #(.VALUE_W(VALUE_W), .DIGITS(DIGITS)) u_b2b (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_vld   (value_vld),
      .value_rdy   (value_rdy),
      .frame_start (frame_start),
      .bcd         (bcd),
      .ovf         (ovf),
      .commit      (commit)
   );

   // Leading-zero blanking walks from the most significant nibble down; nibble 0 always shows
   always_comb begin
      codes_nxt = '0;
      seen      = 1'b0;
      for (int k = DIGITS-1; k >= 0; k--) begin
         if (bcd[k*4 +: 4] != 4'd0) seen = 1'b1;
         if (ovf)                   codes_nxt[k*4 +: 4] = GLYPH_DASH;
         else if (seen || k == 0)   codes_nxt[k*4 +: 4] = bcd[k*4 +: 4];
         else                       codes_nxt[k*4 +: 4] = GLYPH_BLANK;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DIGITS; k++) disp[k*4 +: 4] <= (k == 0) ? 4'd0 : GLYPH_BLANK;
      end else if (commit) begin
         disp <= codes_nxt;
      end
   end

   logic blank_lit;
`ifdef VGA_NUM_BLINK_EN
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
   assign blank_lit = blink & blink_phase;
`else
   assign blank_lit = 1'b0;
`endif

   // Stage 1: locate the cell with one comparator pair per cell, leftmost cell is index 0
   int         hx, vy;
   logic       hit_c;
   logic [2:0] cell_c;
   logic [9:0] lx_c, ly_c;
   logic       s1_hit;
   logic [2:0] s1_cell;
   logic [9:0] s1_x, s1_y;

   always_comb begin
      hx     = int'(h_cnt);
      vy     = int'(v_cnt);
      hit_c  = 1'b0;
      cell_c = '0;
      lx_c   = '0;
      ly_c   = v_cnt - Y0;
      if (vy >= int'(Y0) && vy < int'(Y0) + CELL_H) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (hx >= int'(X0) + i*PITCH && hx < int'(X0) + i*PITCH + CELL_W) begin
               hit_c  = 1'b1;
               cell_c = 3'(i);
               lx_c   = 10'(hx - int'(X0) - i*PITCH);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_hit  <= 1'b0;
         s1_cell <= '0;
         s1_x    <= '0;
         s1_y    <= '0;
      end else begin
         s1_hit  <= hit_c;
         s1_cell <= cell_c;
         s1_x    <= lx_c;
         s1_y    <= ly_c;
      end
   end

   // Stage 2: segment hit test and theme colour
   int         lx, ly;
   logic [3:0] code_c;
   logic [8:0] segs;
   logic       left, right, centre, upper, lower, mid, lit;
   logic [11:0] pixel_nxt;

   always_comb begin
      lx     = int'(s1_x);
      ly     = int'(s1_y);
      code_c = disp[(DIGITS-1-int'(s1_cell))*4 +: 4];
      segs   = code2seg(code_c);
      left   = lx < SEG_THK;
      right  = lx >= SEG_THK + SEG_LEN;
      centre = !left && !right;
      upper  = ly < SEG_THK + SEG_LEN;
      lower  = ly >= 2*SEG_THK + SEG_LEN;
      mid    = !upper && !lower;
      lit    = (segs[0] && ly < SEG_THK) ||
               (segs[1] && right && upper) ||
               (segs[2] && right && lower) ||
               (segs[3] && ly >= CELL_H - SEG_THK) ||
               (segs[4] && left && lower) ||
               (segs[5] && left && upper) ||
               (segs[6] && centre && mid) ||
               (segs[7] && right && mid) ||
               (segs[8] && left && mid);
      pixel_nxt = (s1_hit && lit && !blank_lit) ? theme_fg(theme) : theme_bg(theme);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel    <= 12'h000;
         in_field <= 1'b0;
      end else begin
         pixel    <= pixel_nxt;
         in_field <= s1_hit;
      end
   end

endmodule

// File: tb/tb_vga_num_field.sv
// tb/tb_vga_num_field.sv - directed self-checking bench for vga_num_field
module tb_vga_num_field;

   localparam int VW = 14;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [VW-1:0] value = '0;
   logic          value_vld = 1'b0;
   logic          value_rdy;
   logic          frame_start = 1'b0;
   logic [1:0]    theme = 2'd0;
   logic [9:0]    h_cnt = '0;
   logic [9:0]    v_cnt = '0;
   logic [11:0]   pixel;
   logic          in_field;
`ifdef VGA_NUM_BLINK_EN
   logic          blink = 1'b0;
`endif

   int checks = 0;
   int failures = 0;
   int lowcnt;

   vga_num_field #(.BLINK_FRAMES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .value_vld   (value_vld),
      .value_rdy   (value_rdy),
      .frame_start (frame_start),
      .theme       (theme),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
`ifdef VGA_NUM_BLINK_EN
      .blink       (blink),
`endif
      .pixel       (pixel),
      .in_field    (in_field)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic probe(input int h, input int v, input logic [11:0] exp_pix,
                        input logic exp_in, input string tag);
      @(negedge clk);
      h_cnt = 10'(h);
      v_cnt = 10'(v);
      repeat (2) @(negedge clk);
      check({tag, "_pix"}, {20'd0, pixel}, {20'd0, exp_pix});
      check({tag, "_in"}, {31'd0, in_field}, {31'd0, exp_in});
   endtask

   task automatic send(input logic [VW-1:0] v);
      int n;
      n = 0;
      @(negedge clk);
      value = v;
      value_vld = 1'b1;
      while (!value_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("send_rdy", {31'd0, value_rdy}, 32'd1);
      @(negedge clk);
      value_vld = 1'b0;
   endtask

   task automatic frame();
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic show(input logic [VW-1:0] v);
      send(v);
      repeat (VW + 2) @(negedge clk);
      frame();
   endtask

   initial begin
      // reset state
      #2;
      check("rst_rdy", {31'd0, value_rdy}, 32'd1);
      check("rst_pix", {20'd0, pixel}, 32'h000);
      check("rst_in", {31'd0, in_field}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      probe(100, 16, 12'hFFF, 1'b1, "rst_c3_top");
      probe(110, 38, 12'h000, 1'b1, "rst_c3_mid");
      probe(16, 16, 12'h000, 1'b1, "rst_c0_blank");
      probe(40, 16, 12'h000, 1'b0, "gap");
      probe(15, 16, 12'h000, 1'b0, "left_of_field");

      // 1234 held in PEND for 100 cycles, with a stray frame_start during SHIFT
      @(negedge clk);
      value = 14'd1234;
      value_vld = 1'b1;
      h_cnt = 10'd110;
      v_cnt = 10'd38;
      check("rdy_before_1234", {31'd0, value_rdy}, 32'd1);
      @(negedge clk);
      value_vld = 1'b0;
      lowcnt = 0;
      for (int i = 0; i < 114; i++) begin
         frame_start = (i == 5);
         if (!value_rdy) lowcnt++;
         if (i == 110) check("pend_no_commit", {20'd0, pixel}, 32'h000);
         @(negedge clk);
      end
      frame_start = 1'b1;
      if (!value_rdy) lowcnt++;
      @(negedge clk);
      frame_start = 1'b0;
      check("rdy_after_commit", {31'd0, value_rdy}, 32'd1);
      check("rdy_low_cycles", lowcnt, VW + 1 + 100);
      repeat (3) @(negedge clk);
      check("c3_4_mid", {20'd0, pixel}, 32'hFFF);
      probe(38, 26, 12'hFFF, 1'b1, "c0_1_ur");
      probe(18, 26, 12'h000, 1'b1, "c0_1_ul");
      probe(54, 38, 12'hFFF, 1'b1, "c1_2_mid");
      probe(66, 46, 12'h000, 1'b1, "c1_2_lr");
      probe(74, 46, 12'h000, 1'b1, "c2_3_ll");
      probe(80, 58, 12'hFFF, 1'b1, "c2_3_bot");

      // interior zeros stay visible
      show(14'd1004);
      probe(54, 16, 12'hFFF, 1'b1, "1004_c1_top");
      probe(80, 38, 12'h000, 1'b1, "1004_c2_mid");

      // single digit with leading blanks
      show(14'd7);
      probe(54, 38, 12'h000, 1'b1, "7_c1_blank");
      probe(110, 16, 12'hFFF, 1'b1, "7_c3_top");
      probe(110, 38, 12'h000, 1'b1, "7_c3_mid");
      probe(122, 38, 12'hFFF, 1'b1, "7_c3_joint");

      // overflow boundary
      show(14'd10000);
      probe(26, 38, 12'hFFF, 1'b1, "ovf_c0_mid");
      probe(17, 38, 12'hFFF, 1'b1, "ovf_c0_ljoint");
      probe(26, 16, 12'h000, 1'b1, "ovf_c0_top");
      probe(122, 38, 12'hFFF, 1'b1, "ovf_c3_rjoint");
      show(14'd9999);
      probe(18, 46, 12'h000, 1'b1, "9999_c0_ll");
      probe(110, 16, 12'hFFF, 1'b1, "9999_c3_top");

      // second offer during SHIFT waits for IDLE
      send(14'd42);
      repeat (2) @(negedge clk);
      value = 14'd99;
      value_vld = 1'b1;
      check("rdy_in_shift", {31'd0, value_rdy}, 32'd0);
      repeat (13) @(negedge clk);
      check("rdy_in_pend", {31'd0, value_rdy}, 32'd0);
      @(negedge clk);
      frame_start = 1'b1;
      check("rdy_at_commit", {31'd0, value_rdy}, 32'd0);
      @(negedge clk);
      frame_start = 1'b0;
      check("rdy_back_idle", {31'd0, value_rdy}, 32'd1);
      @(negedge clk);
      check("second_accepted", {31'd0, value_rdy}, 32'd0);
      value_vld = 1'b0;
      probe(73, 26, 12'hFFF, 1'b1, "42_c2_ul");
      probe(122, 46, 12'h000, 1'b1, "42_c3_lr");
      probe(101, 46, 12'hFFF, 1'b1, "42_c3_ll");
      repeat (16) @(negedge clk);
      frame();
      probe(73, 46, 12'h000, 1'b1, "99_c2_ll");
      probe(80, 16, 12'hFFF, 1'b1, "99_c2_top");
      probe(54, 38, 12'h000, 1'b1, "99_c1_blank");

      // themes and two-cycle latency at the field corner
      show(14'd8000);
      theme = 2'd2;
      @(negedge clk);
      h_cnt = 10'd15;
      v_cnt = 10'd16;
      repeat (3) @(negedge clk);
      h_cnt = 10'd16;
      @(negedge clk);
      check("lat_t1_in", {31'd0, in_field}, 32'd0);
      check("lat_t1_pix", {20'd0, pixel}, 32'hE7D);
      @(negedge clk);
      check("lat_t2_in", {31'd0, in_field}, 32'd1);
      check("lat_t2_pix", {20'd0, pixel}, 32'h8F0);
      probe(15, 16, 12'hE7D, 1'b0, "th2_outside");
      theme = 2'd1;
      probe(15, 16, 12'hFFF, 1'b0, "th1_outside");
      probe(16, 16, 12'h000, 1'b1, "th1_seg");
      theme = 2'd3;
      probe(16, 16, 12'hFFF, 1'b1, "th3_seg");
      theme = 2'd0;

      // reset in the middle of SHIFT
      send(14'd77);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_rdy", {31'd0, value_rdy}, 32'd1);
      check("midrst_pix", {20'd0, pixel}, 32'h000);
      check("midrst_in", {31'd0, in_field}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      probe(100, 16, 12'hFFF, 1'b1, "midrst_c3_zero");
      probe(16, 16, 12'h000, 1'b1, "midrst_c0_blank");
      frame();
      probe(16, 16, 12'h000, 1'b1, "idle_fs_no_commit");
      check("idle_fs_rdy", {31'd0, value_rdy}, 32'd1);

`ifdef VGA_NUM_BLINK_EN
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      blink = 1'b1;
      probe(100, 16, 12'hFFF, 1'b1, "blink_on0");
      frame();
      probe(100, 16, 12'hFFF, 1'b1, "blink_on1");
      frame();
      probe(100, 16, 12'h000, 1'b1, "blink_off0");
      blink = 1'b0;
      probe(100, 16, 12'hFFF, 1'b1, "blink_req_low");
      blink = 1'b1;
      frame();
      probe(100, 16, 12'h000, 1'b1, "blink_off1");
      frame();
      probe(100, 16, 12'hFFF, 1'b1, "blink_on2");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
